booth_pp_stream: RTL and testbench
==================================

// Module: booth_pp_stream
// PURPOSE
//  Parametrised radix-4 Booth partial-product generator; successor to the fixed 8x8 shift-and-add PP generator.
//  Accepts one operand pair per transaction (valid/ready), then streams the recoded partial products one per beat.
//  Each beat is fully shifted and sign-extended to 2*WIDTH bits, for the serial accumulator / Wallace-tree feeder.
//  Runtime signed/unsigned mode. The 2*WIDTH-bit sum of all beats equals A*B mod 2^(2*WIDTH).
// PARAMETERS
//  WIDTH   8   operand width; even, >=4
//  (local) OUT_W  = 2*WIDTH                      partial-product width
//  (local) NUM_PP = WIDTH/2+1                    max digits per op (unsigned mode; signed mode uses WIDTH/2)
//  (local) IDX_W  = $clog2(NUM_PP)               digit-index width
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       operand pair valid
//  in_ready   out  1       block idle, can accept
//  in_a       in   WIDTH   multiplicand
//  in_b       in   WIDTH   multiplier (Booth-recoded)
//  in_signed  in   1       1: two's-complement operands; 0: unsigned
//  pp_valid   out  1       partial product valid
//  pp_ready   in   1       downstream accepts PP
//  pp_data    out  OUT_W   signed PP = digit_i * A << 2i, two's complement
//  pp_idx     out  IDX_W   Booth digit index i of current beat
//  pp_last    out  1       final beat of this operation
//  busy       out  1       operation in progress (= !in_ready)
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1, pp_valid=0, pp_data=0, pp_idx=0, pp_last=0, busy=0.
//  FSM IDLE -> EMIT -> IDLE:
//   - IDLE: in_ready=1. On in_valid&in_ready, latch A, B, and mode. Go to EMIT.
//   - EMIT: pp_valid=1. On pp_valid&pp_ready, advance to the next digit.
//     Handshake on the pp_last beat: return to IDLE.
//   - in_ready=0 throughout EMIT. New operand accepted no earlier than the cycle after the last PP handshake.
//  Extension at accept:
//   - A is extended to WIDTH+1 bits: sign bit in signed mode, 0 in unsigned mode.
//   - B is extended to WIDTH+2 bits the same way. b[-1]=0.
//   - Digit count: signed WIDTH/2, unsigned WIDTH/2+1.
//  Digit i from {b[2i+1],b[2i],b[2i-1]}:
//   000/111 -> 0; 001/010 -> +1; 011 -> +2; 100 -> -2; 101/110 -> -1.
//  pp_data arithmetic:
//   - Computed at full OUT_W with sign extension; no truncation of significant bits.
//   - Worst cases fit: signed A=-2^(W-1) times -2; unsigned A=2^W-1 times +2.
//  Timing:
//   - Latency: first pp_valid the cycle after input accept.
//   - Beats on consecutive cycles while pp_ready=1. Throughput: one op per digit_count+1 cycles.
//  Stall: while pp_valid&!pp_ready, pp_data, pp_idx and pp_last hold stable. No beat is dropped or repeated.
//  Boundaries:
//   - B=0 still emits all digits, each zero.
//   - pp_idx never wraps. It ends at the last digit.
//   - in_valid during EMIT is ignored (not latched).
//   - Async reset mid-operation aborts the op immediately and restores the reset values; no partial replay after reset.
// CONFIGURATION
//  BOOTH_SKIP_ZERO_EN defined:
//   - Zero digits are not emitted. pp_idx still reports the true digit index.
//   - pp_last is set on the highest nonzero digit, from a nonzero-digit mask computed at accept.
//   - If all digits are zero, exactly one beat: pp_idx=0, pp_data=0, pp_last=1.
//   - Latency is unchanged; the first beat is the lowest nonzero digit.
//  BOOTH_SKIP_ZERO_EN undefined: every digit is emitted, as above.
// TESTING (WIDTH=8)
//  1. Signed A=-128, B=-128:
//     - Beats idx0..3 = 0x0000, 0x0000, 0x0000, 0x4000.
//     - last on idx3; sum 0x4000 (16384).
//  2. Unsigned A=255, B=255:
//     - Five beats = 0xFF01, 0, 0, 0, 0xFF00.
//     - last on idx4; sum mod 2^16 = 0xFE01 (65025).
//  3. Backpressure: signed A=5, B=3; hold pp_ready=0 for 3 cycles at idx1.
//     - pp_data/idx/last stay stable; in_ready=0 throughout.
//     - Beats resume in order; sum=15.
//  4. Reset: assert rst_n=0 at idx2 of an unsigned op.
//     - All outputs reach reset values without waiting for a clock edge.
//     - Next op after release is correct; no leftover beats.
//  5. Random: 2000 ops, random mode, random pp_ready (50% duty), in_valid asserted during EMIT.
//     - Every op: beat sum == reference product.
//     - Beat count = WIDTH/2 (signed) or WIDTH/2+1 (unsigned).
//  6. BOOTH_SKIP_ZERO_EN:
//     - B=0: one beat, idx0, data 0, last=1.
//     - Signed A=-128, B=-128: one beat, idx3, 0x4000, last=1.

Source files
------------

// File: rtl/booth_pp_stream.sv
// Radix-4 Booth partial-product generator: accepts one operand pair, then streams
// shifted, sign-extended partial products one per beat. Optional macro: BOOTH_SKIP_ZERO_EN.
module booth_pp_stream #(
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_a,
    input  logic [WIDTH-1:0]               in_b,
    input  logic                           in_signed,
    output logic                           pp_valid,
    input  logic                           pp_ready,
    output logic [2*WIDTH-1:0]             pp_data,
    output logic [$clog2(WIDTH/2+1)-1:0]   pp_idx,
    output logic                           pp_last,
    output logic                           busy
);
    localparam int OUT_W  = 2 * WIDTH;
    localparam int NUM_PP = WIDTH / 2 + 1;
    localparam int IDX_W  = $clog2(NUM_PP);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    // bv holds {extended B, b[-1]}, so bits [2i+2:2i] are {b[2i+1], b[2i], b[2i-1]}.
    function automatic logic [2:0] digit_bits(input logic [WIDTH+2:0] bv, input int i);
        return bv[2*i +: 3];
    endfunction

    logic [0:0]       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH+2:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;

    logic             accept, fire, is_last;
    logic [WIDTH+2:0] b_in;
    logic [IDX_W-1:0] count_m1_in;
    logic [2:0]       cur_bits;
    logic [OUT_W-1:0] a_x, pp_mag, pp_value;

`ifdef BOOTH_SKIP_ZERO_EN
    logic [NUM_PP-1:0] mask_q, mask_d;
    logic [NUM_PP-1:0] mask_in;

    function automatic logic digit_nz(input logic [2:0] bits);
        return (bits != 3'b000) && (bits != 3'b111);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_PP; i++) begin
            mask_in[i] = digit_nz(digit_bits(b_in, i)) && (i <= int'(count_m1_in));
        end
    end
`endif

    assign pp_valid = (state_q == S_EMIT);
    assign in_ready = !pp_valid;
    assign busy     = pp_valid;
    assign accept   = in_valid && in_ready;
    assign fire     = pp_valid && pp_ready;
    assign is_last  = (idx_q == last_q);

    assign b_in        = {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
    assign count_m1_in = in_signed ? IDX_W'(WIDTH/2 - 1) : IDX_W'(WIDTH/2);

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no path infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        last_d  = last_q;
`ifdef BOOTH_SKIP_ZERO_EN
        mask_d  = mask_q;
`endif
        if (accept) begin
            state_d = S_EMIT;
            a_d     = {in_signed & in_a[WIDTH-1], in_a};
            b_d     = b_in;
`ifdef BOOTH_SKIP_ZERO_EN
            // All-zero mask leaves first and last at digit 0: a single zero beat.
            mask_d = mask_in;
            idx_d  = '0;
            last_d = '0;
            for (int i = NUM_PP - 1; i >= 0; i--) begin
                if (mask_in[i]) idx_d = IDX_W'(i);
            end
            for (int i = 0; i < NUM_PP; i++) begin
                if (mask_in[i]) last_d = IDX_W'(i);
            end
`else
            idx_d  = '0;
            last_d = count_m1_in;
`endif
        end else if (fire) begin
            if (is_last) begin
                state_d = S_IDLE;
                idx_d   = '0;
            end else begin
`ifdef BOOTH_SKIP_ZERO_EN
                for (int i = NUM_PP - 1; i >= 0; i--) begin
                    if (mask_q[i] && (IDX_W'(i) > idx_q)) idx_d = IDX_W'(i);
                end
`else
                idx_d = idx_q + IDX_W'(1);
`endif
            end
        end
    end

    assign cur_bits = digit_bits(b_q, int'(idx_q));
    assign a_x      = {{(OUT_W-WIDTH-1){a_q[WIDTH]}}, a_q};

    always_comb begin
        case (cur_bits)
            3'b001, 3'b010: pp_mag = a_x;
            3'b011:         pp_mag = a_x << 1;
            3'b100:         pp_mag = -(a_x << 1);
            3'b101, 3'b110: pp_mag = -a_x;
            default:        pp_mag = '0;
        endcase
    end

    assign pp_value = pp_mag << {idx_q, 1'b0};
    assign pp_data  = pp_valid ? pp_value : '0;
    assign pp_idx   = pp_valid ? idx_q : '0;
    assign pp_last  = pp_valid && is_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            last_q  <= '0;
`ifdef BOOTH_SKIP_ZERO_EN
            mask_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge next-state values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
`ifdef BOOTH_SKIP_ZERO_EN
            mask_q  <= mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_booth_pp_stream.sv
// Scoreboard bench for booth_pp_stream (WIDTH=8): directed vectors, stall, reset abort, random ops.
module tb_booth_pp_stream;
    localparam int WIDTH = 8;

    logic        clk, rst_n;
    logic        in_valid, in_ready, in_signed;
    logic [7:0]  in_a, in_b;
    logic        pp_valid, pp_ready, pp_last, busy;
    logic [15:0] pp_data;
    logic [2:0]  pp_idx;

    typedef struct {logic [15:0] data; logic [2:0] idx; logic last;} beat_t;
    typedef struct {logic [15:0] prod; int nbeats; bit chk;} op_t;

    op_t   ops[$];
    beat_t beats[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    rand_ready = 0;
    bit    garbage_en = 0;
    logic [15:0] acc = '0;
    int    nb = 0;

    booth_pp_stream #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .pp_valid(pp_valid), .pp_ready(pp_ready),
        .pp_data(pp_data), .pp_idx(pp_idx), .pp_last(pp_last),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Digit value straight from the Booth weighting -2*b[2i+1] + b[2i] + b[2i-1].
    function automatic int model_count(input logic [7:0] b, input bit s);
        logic [10:0] bx;
        int n, nd, d;
        bx = {{2{s & b[7]}}, b, 1'b0};
        nd = s ? WIDTH/2 : WIDTH/2 + 1;
        n  = 0;
        for (int i = 0; i < nd; i++) begin
            d = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
            if (d != 0) n++;
        end
`ifdef BOOTH_SKIP_ZERO_EN
        return (n == 0) ? 1 : n;
`else
        return nd;
`endif
    endfunction

    task automatic push_op(input logic [7:0] a, input logic [7:0] b, input bit s, input bit chk);
        op_t o;
        int sa, sb;
        sa = s ? int'($signed(a)) : int'({24'b0, a});
        sb = s ? int'($signed(b)) : int'({24'b0, b});
        o.prod   = 16'(sa * sb);
        o.nbeats = model_count(b, s);
        o.chk    = chk;
        ops.push_back(o);
    endtask

    task automatic exp_beat(input logic [15:0] d, input logic [2:0] i, input logic l);
        beat_t e;
        e.data = d; e.idx = i; e.last = l;
        beats.push_back(e);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit s, input bit chk);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        push_op(a, b, s, chk);
        @(posedge clk);
        #1;
        if (garbage_en) begin
            in_a = 8'($urandom); in_b = 8'($urandom); in_signed = 1'($urandom_range(0, 1));
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (ops.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain", 32'(ops.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready) pp_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: one comparison set per accepted beat, decoupled from stimulus.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc = '0;
            nb  = 0;
        end else if (pp_valid && pp_ready) begin
            if (ops.size() == 0) begin
                check("spurious_beat", 32'(ops.size()), 32'd1);
            end else begin
                op_t   cur;
                beat_t e;
                cur = ops[0];
                if (cur.chk) begin
                    if (beats.size() != 0) begin
                        e = beats.pop_front();
                        check("beat_data", 32'(pp_data), 32'(e.data));
                        check("beat_idx", 32'(pp_idx), 32'(e.idx));
                        check("beat_last", 32'(pp_last), 32'(e.last));
                    end else begin
                        check("beat_table", 32'(beats.size()), 32'd1);
                    end
                end
`ifndef BOOTH_SKIP_ZERO_EN
                check("idx_seq", 32'(pp_idx), 32'(nb));
`endif
                check("last_flag", 32'(pp_last), 32'(nb + 1 == cur.nbeats));
                acc = acc + pp_data;
                nb++;
                if (pp_last || nb >= cur.nbeats) begin
                    check("op_sum", 32'(acc), 32'(cur.prod));
                    check("op_beats", 32'(nb), 32'(cur.nbeats));
                    void'(ops.pop_front());
                    acc = '0;
                    nb  = 0;
                end
            end
        end
    end

    initial begin
        logic [15:0] sd;
        logic [2:0]  si;
        logic        sl;
        int          w;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; pp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_pp_valid", 32'(pp_valid), 32'd0);
        check("rst_pp_data", 32'(pp_data), 32'd0);
        check("rst_pp_idx", 32'(pp_idx), 32'd0);
        check("rst_pp_last", 32'(pp_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Signed -128 * -128: only digit 3 is nonzero (-2).
`ifdef BOOTH_SKIP_ZERO_EN
        exp_beat(16'h4000, 3'd3, 1'b1);
`else
        exp_beat(16'h0000, 3'd0, 1'b0); exp_beat(16'h0000, 3'd1, 1'b0);
        exp_beat(16'h0000, 3'd2, 1'b0); exp_beat(16'h4000, 3'd3, 1'b1);
`endif
        issue(8'h80, 8'h80, 1'b1, 1'b1);
        drain();

        // Unsigned 255 * 255: digit0 = -1, digit4 = +1.
`ifdef BOOTH_SKIP_ZERO_EN
        exp_beat(16'hFF01, 3'd0, 1'b0); exp_beat(16'hFF00, 3'd4, 1'b1);
`else
        exp_beat(16'hFF01, 3'd0, 1'b0); exp_beat(16'h0000, 3'd1, 1'b0);
        exp_beat(16'h0000, 3'd2, 1'b0); exp_beat(16'h0000, 3'd3, 1'b0);
        exp_beat(16'hFF00, 3'd4, 1'b1);
`endif
        issue(8'hFF, 8'hFF, 1'b0, 1'b1);
        drain();

        // B = 0: all digits zero.
`ifdef BOOTH_SKIP_ZERO_EN
        exp_beat(16'h0000, 3'd0, 1'b1);
`else
        for (int i = 0; i < 5; i++) exp_beat(16'h0000, 3'(i), i == 4);
`endif
        issue(8'd77, 8'h00, 1'b0, 1'b1);
        drain();

        // Signed 5 * 3 with a 3-cycle stall on digit 1.
`ifdef BOOTH_SKIP_ZERO_EN
        exp_beat(16'hFFFB, 3'd0, 1'b0); exp_beat(16'h0014, 3'd1, 1'b1);
`else
        exp_beat(16'hFFFB, 3'd0, 1'b0); exp_beat(16'h0014, 3'd1, 1'b0);
        exp_beat(16'h0000, 3'd2, 1'b0); exp_beat(16'h0000, 3'd3, 1'b1);
`endif
        issue(8'd5, 8'd3, 1'b1, 1'b1);
        w = 0;
        while (!(pp_valid && pp_idx == 3'd1) && w < 20) begin
            @(posedge clk); #1; w++;
        end
        pp_ready = 1'b0;
        check("stall_at_idx1", 32'(pp_idx), 32'd1);
        sd = pp_data; si = pp_idx; sl = pp_last;
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(pp_valid), 32'd1);
            check("stall_data", 32'(pp_data), 32'(sd));
            check("stall_idx", 32'(pp_idx), 32'(si));
            check("stall_last", 32'(pp_last), 32'(sl));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        pp_ready = 1'b1;
        drain();

        // Reset abort at digit 2 of an unsigned op (all four low digits nonzero).
        issue(8'd200, 8'h55, 1'b0, 1'b0);
        w = 0;
        while (!(pp_valid && pp_idx == 3'd2) && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check("abort_at_idx2", 32'(pp_idx), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_pp_valid", 32'(pp_valid), 32'd0);
        check("abort_pp_data", 32'(pp_data), 32'd0);
        check("abort_pp_idx", 32'(pp_idx), 32'd0);
        check("abort_pp_last", 32'(pp_last), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        ops.delete();
        beats.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        issue(8'd200, 8'd100, 1'b0, 1'b0);
        drain();

        // Random ops, random backpressure, junk in_valid during EMIT.
        rand_ready = 1'b1;
        garbage_en = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            issue(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        in_valid   = 1'b0;
        garbage_en = 1'b0;
        drain();
        rand_ready = 1'b0;
        pp_ready   = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
